// File: rtl/button_step_gen_pkg.sv
// Shared types and constants for the button step generator.
package button_step_gen_pkg;

  // Per-button auto-repeat FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_t;

  // Default timing at 50 MHz: 20 ms debounce, 500 ms repeat delay, 100 ms repeat rate
  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 5_000_000;

  // Reduced timing for simulation
  localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;
  localparam int unsigned SIM_REPEAT_DELAY_CYCLES = 10;
  localparam int unsigned SIM_REPEAT_RATE_CYCLES  = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_step_gen_debounce.sv
// Synchroniser + debouncer for one active-low button.
//   clk, rst_n  : clock, async active-low reset
//   btn_n       : raw button, active-low, asynchronous
//   pressed     : registered debounced state, 1 = pressed
//   press_evt   : one-cycle pulse, aligned with pressed rising
//   release_evt : one-cycle pulse, aligned with pressed falling
module button_debounce
  import button_step_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_evt,
  output logic release_evt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          deb_q;   // 1 = released
  logic [CW-1:0] cnt_q;
  logic          mismatch;

  assign mismatch = sync_q[1] ^ deb_q;

  // Two-flop synchroniser, mismatch-run counter, and event detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      deb_q       <= 1'b1;
      cnt_q       <= '0;
      pressed     <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      if (!mismatch) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q <= ~deb_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      // pressed lags deb_q by one cycle; events mark its edges
      pressed     <= ~deb_q;
      press_evt   <= ~pressed & ~deb_q;
      release_evt <= pressed & deb_q;
    end
  end

endmodule

// File: rtl/button_step_gen.sv
// Up/down pushbuttons -> single-cycle increase/decrease strobes with
// debounce, hold-to-repeat and chord lockout.
//   clk, rst_n            : clock, async active-low reset
//   btn_up_n, btn_down_n  : raw buttons, active-low, asynchronous
//   increase, decrease    : one-cycle step strobes, never both high
//   up_held, down_held    : debounced pressed state
module button_step_gen
  import button_step_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up_n,
  input  logic btn_down_n,
  output logic increase,
  output logic decrease,
  output logic up_held,
  output logic down_held
);

  localparam int unsigned TMAX = max_u(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam int unsigned TW   = $clog2(TMAX);
  // Timers count down to zero, so the load value is period-1
  localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE_CYCLES - 1);

  // Index 0 = up, 1 = down
  logic [1:0]    pressed;
  logic [1:0]    press_evt;
  logic [1:0]    release_evt;
  logic          lock;
  step_state_t   state_q [2];
  step_state_t   state_d [2];
  logic [TW-1:0] timer_q [2];
  logic [TW-1:0] timer_d [2];
  logic [1:0]    pulse_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn_up_n),
    .pressed     (pressed[0]),
    .press_evt   (press_evt[0]),
    .release_evt (release_evt[0])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn_down_n),
    .pressed     (pressed[1]),
    .press_evt   (press_evt[1]),
    .release_evt (release_evt[1])
  );

  // Chord: both held. Any press event arriving now is swallowed, so the
  // surviving button stays silent until released and pressed again.
  assign lock = pressed[0] & pressed[1];

  // Next-state / pulse logic for both repeat FSMs
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      pulse_d[i] = 1'b0;
      if (lock) begin
        state_d[i] = ST_IDLE;
        timer_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (press_evt[i]) begin
              pulse_d[i] = 1'b1;
              timer_d[i] = DELAY_LOAD;
              state_d[i] = ST_DELAY;
            end
          end
          ST_DELAY, ST_REPEAT: begin
            // Release wins over a timer expiring in the same cycle
            if (release_evt[i]) begin
              state_d[i] = ST_IDLE;
              timer_d[i] = '0;
            end else if (timer_q[i] == '0) begin
              pulse_d[i] = 1'b1;
              timer_d[i] = RATE_LOAD;
              state_d[i] = ST_REPEAT;
            end else begin
              timer_d[i] = timer_q[i] - TW'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
      increase  <= 1'b0;
      decrease  <= 1'b0;
      up_held   <= 1'b0;
      down_held <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      increase  <= pulse_d[0];
      decrease  <= pulse_d[1];
      up_held   <= pressed[0];
      down_held <= pressed[1];
    end
  end

endmodule
